// File: rtl/ifetch_unit.sv
// Instruction fetch stage: requests the word at pc, holds it for decode
// behind a valid/ready handshake and pulses pc_inc once per delivered word.
module ifetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_inc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, DRAIN} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pc_inc_q, pc_inc_d;
  logic              fetch_err_q, fetch_err_d;
  logic              timeout_hit;

  // The counter holds the number of completed wait cycles since the grant.
  assign timeout_hit = (cnt_q + 8'd1) == TIMEOUT_C;

  assign mem_req     = (state_q == REQ) && !flush;
  assign mem_addr    = pc;
  assign instr_valid = (state_q == FULL);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_inc      = pc_inc_q && !flush;
  assign fetch_err   = fetch_err_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    fetch_pc_d  = fetch_pc_q;
    cnt_d       = cnt_q;
    pc_inc_d    = 1'b0;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mem_req && mem_gnt) begin
          fetch_pc_d = pc;
          cnt_d      = 8'd0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Returning data wins over the timeout; a coincident flush discards it.
        if (mem_rvalid && flush) begin
          state_d = REQ;
        end else if (mem_rvalid) begin
          instr_d    = mem_rdata;
          instr_pc_d = fetch_pc_q;
          pc_inc_d   = 1'b1;
          state_d    = FULL;
        end else if (timeout_hit) begin
          fetch_err_d = 1'b1;
          state_d     = REQ;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      FULL: begin
        if (flush || instr_ready) state_d = REQ;
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d = REQ;
        end else if (timeout_hit) begin
          fetch_err_d = 1'b1;
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      fetch_pc_q  <= '0;
      cnt_q       <= '0;
      pc_inc_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      fetch_pc_q  <= fetch_pc_d;
      cnt_q       <= cnt_d;
      pc_inc_q    <= pc_inc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly downstream of the 16-bit program counter.
- Reads the current `pc`, issues a request/grant/response read to instruction memory and captures the returned word.
- Presents the word to decode through a valid/ready handshake.
- Pulses `pc_inc` back to the PC once per captured instruction. Supports a flush from branch logic and a response timeout with retry.

Parameters:
- ADDR_W, 16, width of `pc`, `mem_addr` and `instr_pc`.
- DATA_W, 16, width of `mem_rdata` and `instr`.
- TIMEOUT, 15, cycles to wait for `mem_rvalid` before abandoning a fetch; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- pc  in  ADDR_W  current program counter value
- flush  in  1  branch/redirect: discard any in-flight or held instruction
- pc_inc  out  1  one-cycle pulse; PC increments on the following edge
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  request address
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- instr_valid  out  1  instruction register holds a valid word
- instr_ready  in  1  decode accepts the word this cycle
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address the instruction was fetched from
- fetch_err  out  1  one-cycle pulse on timeout

Behaviour:
- **Reset (reset=0, async):**
  - State IDLE.
  - `instr`, `instr_pc`, `fetch_pc` and the timeout counter are 0.
  - `pc_inc`, `mem_req`, `instr_valid` and `fetch_err` are 0.
  - Reset mid-operation aborts everything; any later `mem_rvalid` from the aborted fetch arrives while in IDLE or REQ and is ignored.
- **States:** IDLE, REQ, WAIT, FULL, DRAIN.
- **IDLE:** one cycle after reset release, then REQ.
- **REQ:**
  - `mem_req = (state==REQ) && !flush`, combinational.
  - `mem_addr = pc`, combinational.
  - When `mem_req && mem_gnt`: latch `fetch_pc <= pc`, clear the counter, go to WAIT.
  - `flush` in REQ: stay in REQ; no request is presented that cycle.
  - `mem_rvalid` in REQ is ignored.
- **WAIT:**
  - `mem_req = 0`; the counter increments each cycle.
  - On `mem_rvalid`: `instr <= mem_rdata`, `instr_pc <= fetch_pc`, go to FULL. The registered `pc_inc` is 1 in the first FULL cycle.
  - If the counter reaches TIMEOUT without `mem_rvalid`: `fetch_err` = 1 for one cycle, return to REQ (same `pc`, retry) with no `pc_inc`.
  - `flush` in WAIT without `mem_rvalid`: go to DRAIN.
  - `flush` and `mem_rvalid` in the same cycle: the data is discarded, no `pc_inc`, go to REQ.
- **FULL:**
  - `instr_valid = 1`; `instr` and `instr_pc` are stable until accepted.
  - `instr_ready`: `instr_valid` drops next cycle, go to REQ.
  - `flush`: drop the word without handshake, go to REQ. `flush` has priority over `instr_ready`.
  - Output `pc_inc = pc_inc_reg && !flush`, so a redirect in the first FULL cycle suppresses the increment.
- **DRAIN:**
  - Wait for the outstanding `mem_rvalid` and discard it, then REQ.
  - The counter keeps running; on TIMEOUT, pulse `fetch_err` and go to REQ.
  - Further `flush` in DRAIN has no additional effect.
- **Timing:**
  - Minimum fetch: REQ with immediate grant (cycle 0), `mem_rvalid` in cycle 1, `instr_valid` and `pc_inc` in cycle 2.
  - With `instr_ready` held 1, the next REQ is in cycle 3 and sees the incremented `pc`.
  - Throughput is one instruction per 3 cycles.
- **Invariants:**
  - At most one outstanding memory request.
  - Exactly one `pc_inc` per instruction delivered to FULL and not flushed in its first cycle.
  - `pc` must not change while in REQ/WAIT except via redirect accompanied by `flush`.
- **Width and wrap:** all addresses are ADDR_W bits, no arithmetic inside the block. `pc = 16'hFFFF` is fetched normally; the wrap to 0000 is the PC's concern.

Test Plan:
- **Basic fetch:** reset low 2 cycles, pc=0000, gnt=1, rvalid one cycle later with rdata=1234, ready=1 -> mem_addr=0000; instr=1234, instr_pc=0000, instr_valid 1 cycle; pc_inc 1 pulse; next mem_addr=0001.
- **Backpressure:** pc=00A5, rdata=BEEF, ready=0 for 4 cycles then 1 -> instr_valid held 5 cycles with instr=BEEF stable; exactly one pc_inc; no mem_req while FULL.
- **Timeout/retry:** pc=00A7, gnt=1, rvalid never for TIMEOUT=15 cycles -> fetch_err one pulse after 15 WAIT cycles; mem_req reasserts with mem_addr=00A7; no pc_inc.
- **Flush in WAIT:** pc=0093, grant, flush next cycle, stale rvalid rdata=DEAD 2 cycles later, pc then set to 0200 -> DEAD never appears on instr; next mem_addr=0200; no pc_inc for 0093.
- **Flush with rvalid same cycle / in first FULL cycle:** flush coincident with rvalid rdata=5555 -> instr_valid stays 0, pc_inc 0; flush in first FULL cycle -> instr_valid drops next cycle, pc_inc 0.
- **Async reset mid-WAIT:** reset=0 between clock edges -> all outputs 0 immediately; later rvalid ignored; after release, IDLE then REQ at current pc.
